id_ex_stage: RTL

//  ID/EX pipeline register plus EX-side operand forwarding for the RV32I pipeline.

---
 rtl/rv32_pkg.sv | 52 +++++
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage_fwd_sel.sv | 35 +++
 rtl/id_ex_stage.sv | 98 +++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the RV32I ID/EX stage.
//   XLEN, RA_W   datapath and register-address widths
//   ULA_*        ALU opcode encoding driven on ex_ula_op
//   fwd_sel_e    operand source chosen by the forwarding logic
//   ex_regs_t    contents of the ID/EX pipeline register
package rv32_pkg;
   localparam int XLEN = 32;
   localparam int RA_W = 5;

   typedef logic [3:0] ula_op_t;
   localparam ula_op_t ULA_ADD  = 4'b0000;
   localparam ula_op_t ULA_SUB  = 4'b0001;
   localparam ula_op_t ULA_XOR  = 4'b0010;
   localparam ula_op_t ULA_OR   = 4'b0011;
   localparam ula_op_t ULA_AND  = 4'b0100;
   localparam ula_op_t ULA_SLL  = 4'b0101;
   localparam ula_op_t ULA_SRL  = 4'b0110;
   localparam ula_op_t ULA_SRA  = 4'b0111;
   localparam ula_op_t ULA_SLT  = 4'b1000;
   localparam ula_op_t ULA_SLTU = 4'b1001;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

   // An all-zero value is a bubble: invalid, no side effects, opcode ADD.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
      ula_op_t         ula_op;
      logic            src_a_pc;
      logic            src_b_imm;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } ex_regs_t;

   // A later-stage write hits a source only when it targets that register and
   // the register is not x0 (x0 is hardwired to zero).
   function automatic logic fwd_hit(input logic we, input logic [RA_W-1:0] rd,
                                    input logic [RA_W-1:0] idx);
      return we && (rd == idx) && (idx != '0);
   endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundle between the ID/MEM/WB side of the pipeline and the
// ID/EX stage.
//   id_*    decoded instruction presented by ID
//   mem_*   destination and result of the instruction in MEM
//   wb_*    destination and result of the instruction in WB
//   ex_*    operands and control driven to EX and downstream
//   load_use_haz  load in EX feeds an ID source; upstream must stall/flush
// master: the surrounding pipeline; slave: id_ex_stage.
interface id_ex_stage_if import rv32_pkg::*; ();
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic [RA_W-1:0] id_rs1;
   logic [RA_W-1:0] id_rs2;
   logic [RA_W-1:0] id_rd;
   logic [3:0]      id_ula_op;
   logic            id_src_a_pc;
   logic            id_src_b_imm;
   logic            id_reg_write;
   logic            id_mem_read;
   logic            id_mem_write;

   logic [RA_W-1:0] mem_rd;
   logic            mem_reg_write;
   logic [XLEN-1:0] mem_fwd_data;
   logic [RA_W-1:0] wb_rd;
   logic            wb_reg_write;
   logic [XLEN-1:0] wb_data;

   logic [XLEN-1:0] ex_a;
   logic [XLEN-1:0] ex_b;
   logic [3:0]      ex_ula_op;
   logic [XLEN-1:0] ex_store_data;
   logic [XLEN-1:0] ex_pc;
   logic [RA_W-1:0] ex_rd;
   logic            ex_valid;
   logic            ex_reg_write;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic            load_use_haz;

   modport master (
      output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
             id_rd, id_ula_op, id_src_a_pc, id_src_b_imm, id_reg_write,
             id_mem_read, id_mem_write,
             mem_rd, mem_reg_write, mem_fwd_data, wb_rd, wb_reg_write, wb_data,
      input  ex_a, ex_b, ex_ula_op, ex_store_data, ex_pc, ex_rd, ex_valid,
             ex_reg_write, ex_mem_read, ex_mem_write, load_use_haz
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
             id_rd, id_ula_op, id_src_a_pc, id_src_b_imm, id_reg_write,
             id_mem_read, id_mem_write,
             mem_rd, mem_reg_write, mem_fwd_data, wb_rd, wb_reg_write, wb_data,
      output ex_a, ex_b, ex_ula_op, ex_store_data, ex_pc, ex_rd, ex_valid,
             ex_reg_write, ex_mem_read, ex_mem_write, load_use_haz
   );
endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// fwd_sel: operand forwarding for one EX source register.
//   idx            source register index latched in EX
//   rf_data        register-file value latched in EX
//   mem_*, wb_*    destination/write-enable/value of the MEM and WB instructions
//   sel            chosen source (FWD_RF / FWD_MEM / FWD_WB)
//   data           forwarded operand value
// MEM is younger than WB, so it wins when both target the same register.
module fwd_sel import rv32_pkg::*; (
   input  logic [RA_W-1:0] idx,
   input  logic [XLEN-1:0] rf_data,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            mem_reg_write,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_data,
   output fwd_sel_e        sel,
   output logic [XLEN-1:0] data
);
   always_comb begin
      sel = FWD_RF;
      if (fwd_hit(mem_reg_write, mem_rd, idx))
         sel = FWD_MEM;
      else if (fwd_hit(wb_reg_write, wb_rd, idx))
         sel = FWD_WB;
   end

   always_comb begin
      case (sel)
         FWD_MEM: data = mem_fwd_data;
         FWD_WB:  data = wb_data;
         default: data = rf_data;
      endcase
   end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand forwarding.
//   clk, rst   clock; synchronous active-high reset
//   stall      hold EX contents (forwarded operand data still refreshed)
//   flush      load a bubble into EX on the next edge
//   bus        id_ex_stage_if.slave: ID inputs, MEM/WB forwarding sources,
//              EX operands/control, load_use_haz
// Edge priority: rst > flush > stall > load from ID.
module id_ex_stage import rv32_pkg::*; (
   input logic         clk,
   input logic         rst,
   input logic         stall,
   input logic         flush,
   id_ex_stage_if.slave bus
);
   ex_regs_t        ex_q;
   ex_regs_t        id_d;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   fwd_sel_e        sel_rs1;
   fwd_sel_e        sel_rs2;

   always_comb begin
      id_d           = '0;
      id_d.valid     = bus.id_valid;
      id_d.pc        = bus.id_pc;
      id_d.rs1_data  = bus.id_rs1_data;
      id_d.rs2_data  = bus.id_rs2_data;
      id_d.imm       = bus.id_imm;
      id_d.rs1       = bus.id_rs1;
      id_d.rs2       = bus.id_rs2;
      id_d.rd        = bus.id_rd;
      id_d.ula_op    = bus.id_ula_op;
      id_d.src_a_pc  = bus.id_src_a_pc;
      id_d.src_b_imm = bus.id_src_b_imm;
      id_d.reg_write = bus.id_reg_write;
      id_d.mem_read  = bus.id_mem_read;
      id_d.mem_write = bus.id_mem_write;
   end

   fwd_sel u_fwd_rs1 (
      .idx          (ex_q.rs1),
      .rf_data      (ex_q.rs1_data),
      .mem_rd       (bus.mem_rd),
      .mem_reg_write(bus.mem_reg_write),
      .mem_fwd_data (bus.mem_fwd_data),
      .wb_rd        (bus.wb_rd),
      .wb_reg_write (bus.wb_reg_write),
      .wb_data      (bus.wb_data),
      .sel          (sel_rs1),
      .data         (fwd_rs1)
   );

   fwd_sel u_fwd_rs2 (
      .idx          (ex_q.rs2),
      .rf_data      (ex_q.rs2_data),
      .mem_rd       (bus.mem_rd),
      .mem_reg_write(bus.mem_reg_write),
      .mem_fwd_data (bus.mem_fwd_data),
      .wb_rd        (bus.wb_rd),
      .wb_reg_write (bus.wb_reg_write),
      .wb_data      (bus.wb_data),
      .sel          (sel_rs2),
      .data         (fwd_rs2)
   );

   // Select codes are only of interest when probing the design.
   logic sel_unused;
   assign sel_unused = ^{sel_rs1, sel_rs2};

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_q <= '0;
      end else if (stall) begin
         // Capture forwarded values while held, so a producer that retires out
         // of WB during the stall is not lost once its bypass disappears.
         ex_q.rs1_data <= fwd_rs1;
         ex_q.rs2_data <= fwd_rs2;
      end else begin
         ex_q <= id_d;
      end
   end

   assign bus.ex_a          = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
   assign bus.ex_b          = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
   assign bus.ex_store_data = fwd_rs2;
   assign bus.ex_ula_op     = ex_q.ula_op;
   assign bus.ex_pc         = ex_q.pc;
   assign bus.ex_rd         = ex_q.rd;
   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_reg_write  = ex_q.reg_write;
   assign bus.ex_mem_read   = ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.mem_write;

   // Load data only exists after MEM, so an immediately dependent instruction
   // in ID cannot be bypassed and must wait one cycle.
   assign bus.load_use_haz = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                             ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));
endmodule
